// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Single-port memory arbiter for loader, datapath and fetch
//            requesters with an IDLE/ACCESS/DONE FSM clocked on the falling
//            edge. Define MEM_ARB_ROUND_ROBIN_EN to alternate fetch and data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_ACCESS  = 2'd1;
    localparam logic [1:0] c_S_DONE    = 2'd2;

    localparam logic [1:0] c_GNT_NONE  = 2'b00;
    localparam logic [1:0] c_GNT_FETCH = 2'b01;
    localparam logic [1:0] c_GNT_DATA  = 2'b10;
    localparam logic [1:0] c_GNT_LOAD  = 2'b11;

    localparam logic [2:0] c_CNT_INIT  = 3'(WAIT_CYC - 1);

    logic [1:0]        r_state,   w_state_nxt;
    logic [1:0]        r_grant,   w_grant_nxt;
    logic [2:0]        r_cnt,     w_cnt_nxt;
    logic              r_we,      w_we_nxt;
    logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
    logic [DATA_W-1:0] r_wdata,   w_wdata_nxt;
    logic              r_mem_re,  w_mem_re_nxt;
    logic              r_mem_we,  w_mem_we_nxt;
    logic [DATA_W-1:0] r_rdata,   w_rdata_nxt;
    logic              r_ld_ack,  w_ld_ack_nxt;
    logic              r_d_ack,   w_d_ack_nxt;
    logic              r_f_ack,   w_f_ack_nxt;
    logic              w_start;
    logic [1:0]        w_pick;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              r_rr_fetch_last, w_rr_fetch_last_nxt;
`endif

    // Loader always wins; fetch/data ordering depends on the build option.
    always_comb begin
        w_pick = c_GNT_NONE;
        if (ld_req) begin
            w_pick = c_GNT_LOAD;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        end else if (d_req && (!f_req || r_rr_fetch_last)) begin
            w_pick = c_GNT_DATA;
`else
        end else if (d_req) begin
            w_pick = c_GNT_DATA;
`endif
        end else if (f_req) begin
            w_pick = c_GNT_FETCH;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_cnt_nxt    = r_cnt;
        w_we_nxt     = r_we;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_mem_re_nxt = 1'b0;
        w_mem_we_nxt = 1'b0;
        w_rdata_nxt  = r_rdata;
        w_ld_ack_nxt = 1'b0;
        w_d_ack_nxt  = 1'b0;
        w_f_ack_nxt  = 1'b0;
        w_start      = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                if (w_pick != c_GNT_NONE) begin
                    w_start     = 1'b1;
                    w_state_nxt = c_S_ACCESS;
                    w_grant_nxt = w_pick;
                    w_cnt_nxt   = c_CNT_INIT;
                    case (w_pick)
                        c_GNT_LOAD: begin
                            w_addr_nxt  = ld_addr;
                            w_wdata_nxt = ld_wdata;
                            w_we_nxt    = ld_we;
                        end
                        c_GNT_DATA: begin
                            w_addr_nxt  = d_addr;
                            w_wdata_nxt = d_wdata;
                            w_we_nxt    = d_we;
                        end
                        default: begin
                            w_addr_nxt  = f_addr;
                            w_wdata_nxt = '0;
                            w_we_nxt    = 1'b0;
                        end
                    endcase
                    w_mem_re_nxt = !w_we_nxt;
                    w_mem_we_nxt = w_we_nxt;
                end
            end
            c_S_ACCESS: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = c_S_DONE;
                    if (!r_we) begin
                        w_rdata_nxt = mem_rdata;
                    end
                    w_ld_ack_nxt = (r_grant == c_GNT_LOAD);
                    w_d_ack_nxt  = (r_grant == c_GNT_DATA);
                    w_f_ack_nxt  = (r_grant == c_GNT_FETCH);
                end else begin
                    w_cnt_nxt    = r_cnt - 3'd1;
                    w_mem_re_nxt = !r_we;
                    w_mem_we_nxt = r_we;
                end
            end
            c_S_DONE: begin
                // A locked data burst keeps the port without re-arbitrating.
                if ((r_grant == c_GNT_DATA) && d_lock && d_req) begin
                    w_start      = 1'b1;
                    w_state_nxt  = c_S_ACCESS;
                    w_cnt_nxt    = c_CNT_INIT;
                    w_addr_nxt   = d_addr;
                    w_wdata_nxt  = d_wdata;
                    w_we_nxt     = d_we;
                    w_mem_re_nxt = !d_we;
                    w_mem_we_nxt = d_we;
                end else begin
                    w_state_nxt = c_S_IDLE;
                    w_grant_nxt = c_GNT_NONE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_grant_nxt = c_GNT_NONE;
            end
        endcase
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        w_rr_fetch_last_nxt = r_rr_fetch_last;
        if (w_start) begin
            if (w_grant_nxt == c_GNT_FETCH) begin
                w_rr_fetch_last_nxt = 1'b1;
            end else if (w_grant_nxt == c_GNT_DATA) begin
                w_rr_fetch_last_nxt = 1'b0;
            end
        end
    end
`endif

    always_ff @(negedge clk) begin
        if (proc_rst) begin
            r_state  <= c_S_IDLE;
            r_grant  <= c_GNT_NONE;
            r_cnt    <= 3'd0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_rdata  <= '0;
            r_ld_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            r_f_ack  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_rr_fetch_last <= 1'b1;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_cnt    <= w_cnt_nxt;
            r_we     <= w_we_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_mem_re <= w_mem_re_nxt;
            r_mem_we <= w_mem_we_nxt;
            r_rdata  <= w_rdata_nxt;
            r_ld_ack <= w_ld_ack_nxt;
            r_d_ack  <= w_d_ack_nxt;
            r_f_ack  <= w_f_ack_nxt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_rr_fetch_last <= w_rr_fetch_last_nxt;
`endif
        end
    end

    assign ld_ack    = r_ld_ack;
    assign d_ack     = r_d_ack;
    assign f_ack     = r_f_ack;
    assign rdata     = r_rdata;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign grant     = r_grant;
    assign busy      = (r_state != c_S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter; a WAIT_CYC=1 and a WAIT_CYC=3
//            instance share stimulus and a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int W  = 1;
    localparam int W3 = 3;

    typedef struct packed {
        logic [1:0]  grant;
        logic [15:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        proc_rst;
    logic        ld_req, ld_we, d_req, d_we, d_lock, f_req;
    logic [15:0] ld_addr, ld_wdata, d_addr, d_wdata, f_addr;

    logic        ld_ack, d_ack, f_ack, mem_re, mem_we, busy;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant;

    logic        ld_ack3, d_ack3, f_ack3, mem_re3, mem_we3, busy3;
    logic [15:0] rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic [1:0]  grant3;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [15:0] shadow [int];

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [7:0] a);
        return (a == 8'h10) ? 16'hABCD : {a ^ 8'hA5, a};
    endfunction

    function automatic logic [15:0] exp_rd(input logic [15:0] a);
        if (shadow.exists(int'(a[7:0]))) return shadow[int'(a[7:0])];
        return pat(a[7:0]);
    endfunction

    // Behavioural memory: pattern contents until written by the W=1 instance.
    logic        mem_clear;
    logic [15:0] dev_data  [0:255];
    logic        dev_valid [0:255];

    always @(negedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) dev_valid[i] <= 1'b0;
        end else if (mem_we) begin
            dev_data[mem_addr[7:0]]  <= mem_wdata;
            dev_valid[mem_addr[7:0]] <= 1'b1;
        end
    end

    assign mem_rdata  = dev_valid[mem_addr[7:0]]  ? dev_data[mem_addr[7:0]]  : pat(mem_addr[7:0]);
    assign mem_rdata3 = dev_valid[mem_addr3[7:0]] ? dev_data[mem_addr3[7:0]] : pat(mem_addr3[7:0]);

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(W)) dut (
        .clk(clk), .proc_rst(proc_rst),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(W3)) dut3 (
        .clk(clk), .proc_rst(proc_rst),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack3),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack3),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack3),
        .rdata(rdata3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_re(mem_re3), .mem_we(mem_we3),
        .mem_rdata(mem_rdata3), .grant(grant3), .busy(busy3)
    );

    task automatic clear_inputs();
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        d_req  = 1'b0; d_we  = 1'b0; d_lock  = 1'b0; d_addr = '0; d_wdata = '0;
        f_req  = 1'b0; f_addr = '0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        proc_rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        proc_rst = 1'b0;
        exp_q.delete();
    endtask

    // Returns the number of rising edges until the selected ack, or -1.
    task automatic wait_ack(input int which, input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit && cycles < 0; i++) begin
            @(posedge clk);
            case (which)
                1:       if (f_ack === 1'b1) cycles = i;
                2:       if (d_ack === 1'b1) cycles = i;
                3:       if (ld_ack === 1'b1) cycles = i;
                4:       if (f_ack === 1'b1 || d_ack === 1'b1) cycles = i;
                default: if (f_ack === 1'b1 || d_ack === 1'b1 || ld_ack === 1'b1) cycles = i;
            endcase
        end
    endtask

    task automatic test_reset();
        mem_clear = 1'b1;
        proc_rst  = 1'b1;
        clear_inputs();
        f_req = 1'b1; d_req = 1'b1; ld_req = 1'b1;
        repeat (3) @(posedge clk);
        checks++; if (busy !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL reset_state: busy=%b grant=%b expected 0/00", busy, grant); end
        checks++; if ({ld_ack, d_ack, f_ack} !== 3'b000) begin errors++; $display("FAIL reset_acks: got %b expected 000", {ld_ack, d_ack, f_ack}); end
        checks++; if ({mem_re, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem_ctl: got %b expected 00", {mem_re, mem_we}); end
        checks++; if (rdata !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h expected 0", rdata, mem_addr, mem_wdata); end
        checks++; if (busy3 !== 1'b0 || grant3 !== 2'b00 || mem_wdata3 !== 16'h0) begin errors++; $display("FAIL reset_dut3: busy=%b grant=%b wdata=%h expected 0", busy3, grant3, mem_wdata3); end
        mem_clear = 1'b0;
        clear_inputs();
        proc_rst = 1'b0;
    endtask

    task automatic test_fetch_read();
        int   cyc;
        exp_t e;
        apply_reset();
        @(posedge clk);
        f_req = 1'b1; f_addr = 16'h0010;
        exp_q.push_back('{2'b01, exp_rd(16'h0010)});
        @(posedge clk);
        checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem_re: re=%b we=%b expected re=1 we=0", mem_re, mem_we); end
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL fetch_addr: got %h expected 0010", mem_addr); end
        checks++; if (grant !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL fetch_grant_access: grant=%b busy=%b expected 01/1", grant, busy); end
        wait_ack(1, 20, cyc);
        e = exp_q.pop_front();
        checks++; if (cyc + 1 != W + 1) begin errors++; $display("FAIL fetch_latency: got %0d expected %0d", cyc + 1, W + 1); end
        checks++; if (grant !== e.grant) begin errors++; $display("FAIL fetch_grant: got %b expected %b", grant, e.grant); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL fetch_rdata: got %h expected %h", rdata, e.rdata); end
        checks++; if ({mem_re, mem_we} !== 2'b00) begin errors++; $display("FAIL fetch_done_mem: got %b expected 00", {mem_re, mem_we}); end
        f_req = 1'b0;
        @(posedge clk);
        checks++; if (grant !== 2'b00 || busy !== 1'b0 || f_ack !== 1'b0) begin errors++; $display("FAIL fetch_idle: grant=%b busy=%b ack=%b expected 00/0/0", grant, busy, f_ack); end
        @(posedge clk);
        checks++; if (busy !== 1'b0 || f_ack !== 1'b0) begin errors++; $display("FAIL fetch_no_retrigger: busy=%b ack=%b expected 0/0", busy, f_ack); end
    endtask

    task automatic test_data_write_read();
        int   cyc, we_cnt;
        logic re_seen, bad_bus;
        exp_t e;
        apply_reset();
        @(posedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        shadow[32] = 16'h1234;
        exp_q.push_back('{2'b10, 16'h0000});
        we_cnt = 0; re_seen = 1'b0; bad_bus = 1'b0; cyc = -1;
        for (int i = 1; i <= 20 && cyc < 0; i++) begin
            @(posedge clk);
            if (mem_we === 1'b1) begin
                we_cnt++;
                if (mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) bad_bus = 1'b1;
            end
            if (mem_re === 1'b1) re_seen = 1'b1;
            if (d_ack === 1'b1) cyc = i;
        end
        e = exp_q.pop_front();
        checks++; if (cyc != W + 1) begin errors++; $display("FAIL write_latency: got %0d expected %0d", cyc, W + 1); end
        checks++; if (we_cnt != W) begin errors++; $display("FAIL write_we_cycles: got %0d expected %0d", we_cnt, W); end
        checks++; if (bad_bus !== 1'b0) begin errors++; $display("FAIL write_bus: got bad=%b expected 0", bad_bus); end
        checks++; if (re_seen !== 1'b0) begin errors++; $display("FAIL write_no_re: got %b expected 0", re_seen); end
        checks++; if (grant !== e.grant || rdata !== e.rdata) begin errors++; $display("FAIL write_ack: grant=%b rdata=%h expected %b/%h", grant, rdata, e.grant, e.rdata); end
        d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
        @(posedge clk);
        d_req = 1'b1; d_addr = 16'h0020;
        exp_q.push_back('{2'b10, exp_rd(16'h0020)});
        wait_ack(2, 20, cyc);
        e = exp_q.pop_front();
        checks++; if (cyc != W + 1) begin errors++; $display("FAIL readback_latency: got %0d expected %0d", cyc, W + 1); end
        checks++; if (grant !== e.grant || rdata !== e.rdata) begin errors++; $display("FAIL readback: grant=%b rdata=%h expected %b/%h", grant, rdata, e.grant, e.rdata); end
        d_req = 1'b0;
    endtask

    task automatic test_contention();
        int         cyc;
        logic [1:0] g;
        exp_t       e;
        apply_reset();
        @(posedge clk);
        f_req = 1'b1; f_addr = 16'h0030; d_req = 1'b1; d_addr = 16'h0040;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
            g = 2'b10;
`endif
            exp_q.push_back('{g, (g == 2'b10) ? exp_rd(16'h0040) : exp_rd(16'h0030)});
        end
        for (int k = 0; k < 4; k++) begin
            wait_ack(4, 20, cyc);
            e = exp_q.pop_front();
            checks++; if (cyc != ((k == 0) ? W + 1 : W + 2)) begin errors++; $display("FAIL contend_spacing[%0d]: got %0d expected %0d", k, cyc, (k == 0) ? W + 1 : W + 2); end
            checks++; if (grant !== e.grant || {d_ack, f_ack} !== e.grant) begin errors++; $display("FAIL contend_grant[%0d]: grant=%b acks=%b expected %b", k, grant, {d_ack, f_ack}, e.grant); end
            checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL contend_rdata[%0d]: got %h expected %h", k, rdata, e.rdata); end
            if (k == 3) begin
                f_req = 1'b0; d_req = 1'b0;
            end
        end
    endtask

    task automatic test_locked_burst();
        int   cyc;
        exp_t e;
        apply_reset();
        @(posedge clk);
        d_req = 1'b1; d_lock = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
        for (int k = 0; k < 8; k++) exp_q.push_back('{2'b10, exp_rd(16'h0050 + 16'(k))});
        exp_q.push_back('{2'b11, exp_rd(16'h0060)});
        @(posedge clk);
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0060;
        for (int k = 0; k < 8; k++) begin
            wait_ack(2, 20, cyc);
            e = exp_q.pop_front();
            checks++; if (cyc != ((k == 0) ? W : W + 1)) begin errors++; $display("FAIL burst_spacing[%0d]: got %0d expected %0d", k, cyc, (k == 0) ? W : W + 1); end
            checks++; if (grant !== e.grant || rdata !== e.rdata || ld_ack !== 1'b0) begin errors++; $display("FAIL burst_beat[%0d]: grant=%b rdata=%h ld_ack=%b expected %b/%h/0", k, grant, rdata, ld_ack, e.grant, e.rdata); end
            if (k < 7) begin
                d_addr = 16'h0050 + 16'(k + 1);
            end else begin
                d_req = 1'b0; d_lock = 1'b0;
            end
        end
        wait_ack(3, 20, cyc);
        e = exp_q.pop_front();
        checks++; if (cyc != W + 2) begin errors++; $display("FAIL burst_loader_latency: got %0d expected %0d", cyc, W + 2); end
        checks++; if (grant !== e.grant || rdata !== e.rdata) begin errors++; $display("FAIL burst_loader: grant=%b rdata=%h expected %b/%h", grant, rdata, e.grant, e.rdata); end
        ld_req = 1'b0;
    endtask

    task automatic test_all_rise();
        int   cyc;
        exp_t e;
        apply_reset();
        @(posedge clk);
        ld_req = 1'b1; ld_addr = 16'h0070;
        d_req  = 1'b1; d_addr  = 16'h0071;
        f_req  = 1'b1; f_addr  = 16'h0072;
        exp_q.push_back('{2'b11, exp_rd(16'h0070)});
        wait_ack(5, 20, cyc);
        e = exp_q.pop_front();
        checks++; if (cyc != W + 1) begin errors++; $display("FAIL allrise_latency: got %0d expected %0d", cyc, W + 1); end
        checks++; if ({ld_ack, d_ack, f_ack} !== 3'b100 || grant !== e.grant) begin errors++; $display("FAIL allrise_winner: acks=%b grant=%b expected 100/%b", {ld_ack, d_ack, f_ack}, grant, e.grant); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL allrise_rdata: got %h expected %h", rdata, e.rdata); end
        clear_inputs();
    endtask

    task automatic test_wait3_latency();
        int   cyc, re_cnt;
        exp_t e;
        apply_reset();
        @(posedge clk);
        f_req = 1'b1; f_addr = 16'h0080;
        exp_q.push_back('{2'b01, exp_rd(16'h0080)});
        cyc = -1; re_cnt = 0;
        for (int i = 1; i <= 30 && cyc < 0; i++) begin
            @(posedge clk);
            if (mem_re3 === 1'b1) re_cnt++;
            if (f_ack3 === 1'b1) cyc = i;
        end
        e = exp_q.pop_front();
        checks++; if (cyc != W3 + 1) begin errors++; $display("FAIL w3_latency: got %0d expected %0d", cyc, W3 + 1); end
        checks++; if (re_cnt != W3) begin errors++; $display("FAIL w3_re_cycles: got %0d expected %0d", re_cnt, W3); end
        checks++; if (grant3 !== e.grant || rdata3 !== e.rdata || {ld_ack3, d_ack3} !== 2'b00) begin errors++; $display("FAIL w3_ack: grant=%b rdata=%h other=%b expected %b/%h/00", grant3, rdata3, {ld_ack3, d_ack3}, e.grant, e.rdata); end
        f_req = 1'b0;
    endtask

    task automatic test_reset_abort();
        int ack_cnt;
        apply_reset();
        @(posedge clk);
        f_req = 1'b1; f_addr = 16'h0090;
        @(posedge clk);
        @(posedge clk);
        checks++; if (mem_re3 !== 1'b1 || busy3 !== 1'b1) begin errors++; $display("FAIL abort_inflight: re=%b busy=%b expected 1/1", mem_re3, busy3); end
        proc_rst = 1'b1;
        @(posedge clk);
        checks++; if (mem_re3 !== 1'b0 || mem_we3 !== 1'b0 || f_ack3 !== 1'b0) begin errors++; $display("FAIL abort_mem: re=%b we=%b ack=%b expected 0/0/0", mem_re3, mem_we3, f_ack3); end
        checks++; if (grant3 !== 2'b00 || busy3 !== 1'b0) begin errors++; $display("FAIL abort_state: grant=%b busy=%b expected 00/0", grant3, busy3); end
        proc_rst = 1'b0;
        f_req = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            if (f_ack3 === 1'b1) ack_cnt++;
        end
        checks++; if (ack_cnt != 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks expected 0", ack_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        proc_rst  = 1'b1;
        mem_clear = 1'b1;
        clear_inputs();
        test_reset();
        test_fetch_read();
        test_data_write_read();
        test_contention();
        test_locked_burst();
        test_all_rise();
        test_wait3_latency();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter WAIT_CYC, default 1, memory access cycles per transfer; legal range 1..7.
REQ-004 clk  in  1  clock; all state updates on falling edge of clk, matching the processor controller.
REQ-005 proc_rst  in  1  synchronous reset, active-high.
REQ-006 ld_req, ld_we  in  1 each  loader (program-load/debug) request and write-enable.
REQ-007 ld_addr  in  ADDR_W, ld_wdata  in  DATA_W  loader address and write data.
REQ-008 ld_ack  out  1  loader transfer-complete pulse.
REQ-009 d_req, d_we, d_lock  in  1 each  datapath LW/SW/LM/SM request, write-enable and burst lock.
REQ-010 d_addr  in  ADDR_W, d_wdata  in  DATA_W  datapath address and write data.
REQ-011 d_ack  out  1  datapath transfer-complete pulse.
REQ-012 f_req  in  1, f_addr  in  ADDR_W  instruction-fetch request (read-only).
REQ-013 f_ack  out  1  fetch transfer-complete pulse.
REQ-014 rdata  out  DATA_W  read data for the acked transfer, shared by all requesters.
REQ-015 mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, mem_re  out  1, mem_we  out  1  memory port.
REQ-016 mem_rdata  in  DATA_W  memory read data, valid in the last ACCESS cycle.
REQ-017 grant  out  2  current owner: 00 none, 01 fetch, 10 data, 11 loader.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-020 In IDLE with any req high, the FSM SHALL select a winner, latch its addr/wdata/we (we forced 0 for fetch), load wait counter with WAIT_CYC-1, and enter ACCESS.
REQ-021 In ACCESS, mem_re = !we_latched and mem_we = we_latched, both registered; mem_addr/mem_wdata SHALL hold latched values.
REQ-022 In ACCESS, counter decrements each cycle; at counter 0, rdata SHALL capture mem_rdata (reads only) and the FSM enters DONE.
REQ-023 In DONE, the winner's ack SHALL be high for exactly one cycle, with mem_re = mem_we = 0 and rdata stable.
REQ-024 From DONE, if grant = data and d_lock and d_req are high, the FSM SHALL re-latch data inputs and enter ACCESS with no arbitration; otherwise it SHALL enter IDLE with grant = 00.
REQ-025 Latency: req sampled in IDLE at edge N, ack high in cycle N+1+WAIT_CYC; back-to-back unlocked transfers take WAIT_CYC+2 cycles each.
REQ-026 Loader SHALL have absolute priority at every arbitration point; no requester is preempted mid-transfer.
REQ-027 Requesters SHALL hold req, addr, wdata and we stable until ack; changes after latching SHALL be ignored.
REQ-028 A req dropped before being sampled in IDLE SHALL cause no transfer; a req still high after its ack SHALL be a new request.
REQ-029 Locked bursts SHALL have unbounded length; the loader waits until lock or d_req drops.

Reset
REQ-030 On proc_rst high at a clock edge: state = IDLE, grant = 00, all acks = 0, mem_re = mem_we = 0, rdata = 0, mem_addr = mem_wdata = 0, counter = 0, rr pointer = fetch-last; this SHALL abort any in-flight access with no ack.

Configuration
REQ-031 Macro MEM_ARB_ROUND_ROBIN_EN defined: fetch and data SHALL alternate when both request, using a pointer updated on every fetch or data grant.
REQ-032 Macro MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority loader > data > fetch, no pointer.

Verification
REQ-033 WAIT_CYC=1, f_req with f_addr=0x0010 and mem_rdata=0xABCD -> mem_re in cycle 1, f_ack with rdata=0xABCD in cycle 2, grant=01.
REQ-034 d_req write with d_addr=0x0020 and d_wdata=0x1234 -> mem_we high for WAIT_CYC cycles at 0x0020/0x1234, d_ack pulse, mem_re never high.
REQ-035 f_req and d_req held high continuously -> with macro, grants alternate 10,01,10,...; without macro, data is granted repeatedly and fetch is starved.
REQ-036 d_lock high for 8 data reads while ld_req is high -> 8 consecutive d_acks spaced WAIT_CYC+1 cycles, then loader is granted.
REQ-037 WAIT_CYC=3, proc_rst pulsed in the second ACCESS cycle -> next cycle mem_re=0, no ack, grant=00, busy=0.
REQ-038 ld_req, d_req and f_req all rise on the same edge -> loader is granted first in both configurations.
